// File: rtl/ucie_clk_track_pattern_engine.sv
// Clock/track training pattern generator with per-lane received-edge checker.
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | lanes parked at their idle level, waiting for a start pulse
// RUN   | pattern driven on enabled lanes, received edges counted
// DRAIN | pattern parked, counting continues to catch in-flight edges
// DONE  | per-lane results and counts held until clear or restart
module ucie_clk_track_pattern_engine #(
    parameter int              N_CH      = 3,
    parameter int              ITER      = 128,
    parameter int              ON_CYC    = 8,
    parameter int              OFF_CYC   = 8,
    parameter logic [N_CH-1:0] INV_MASK  = 3'b010,
    parameter int              DRAIN_CYC = 8,
    parameter int              TOL       = 4,
    parameter int              CNT_W     = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_mode,
    input  logic                    i_clear,
    input  logic [N_CH-1:0]         i_ch_en,
    output logic [N_CH-1:0]         o_tx,
    input  logic [N_CH-1:0]         i_rx,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [N_CH-1:0]         o_result,
    output logic                    o_all_pass,
    output logic [N_CH*CNT_W-1:0]   o_edge_cnt
);

    localparam int PERIOD  = ON_CYC + OFF_CYC;
    localparam int RUN_LEN = ITER * PERIOD;
    localparam int TMR_MAX = (RUN_LEN > DRAIN_CYC) ? RUN_LEN : DRAIN_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PH_W    = $clog2(PERIOD + 1);

    localparam logic [CNT_W:0]   E_BURST = (CNT_W+1)'(ITER * ON_CYC / 2);
    localparam logic [CNT_W:0]   E_CONT  = (CNT_W+1)'(RUN_LEN / 2);
    localparam logic [CNT_W:0]   TOL_E   = (CNT_W+1)'(TOL);
    localparam logic [CNT_W+1:0] TOL_H   = (CNT_W+2)'(TOL);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state, state_n;
    logic [TMR_W-1:0]  tmr, tmr_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic              k0, k0_n;
    logic              start_run, finish, clr;
    logic              mode_r, mode_sel;
    logic [N_CH-1:0]   en_r, en_sel;
    logic              pat_bit;
    logic [N_CH-1:0]   tx_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            tmr    <= '0;
            phase  <= '0;
            k0     <= 1'b0;
            mode_r <= 1'b0;
            en_r   <= '0;
            o_tx   <= INV_MASK;
        end else begin
            state  <= state_n;
            tmr    <= tmr_n;
            phase  <= phase_n;
            k0     <= k0_n;
            mode_r <= mode_sel;
            en_r   <= en_sel;
            o_tx   <= tx_n;
        end
    end

    // tmr is a down-counter holding the cycles left in the current timed state
    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        phase_n   = phase;
        k0_n      = k0;
        start_run = 1'b0;
        finish    = 1'b0;
        clr       = 1'b0;
        if (i_clear) begin
            state_n = S_IDLE;
            clr     = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_n   = S_RUN;
                        start_run = 1'b1;
                        tmr_n     = TMR_W'(RUN_LEN - 1);
                        phase_n   = '0;
                        k0_n      = 1'b0;
                    end
                end
                S_RUN: begin
                    if (tmr == '0) begin
                        state_n = S_DRAIN;
                        tmr_n   = TMR_W'(DRAIN_CYC - 1);
                    end else begin
                        tmr_n   = tmr - 1'b1;
                        phase_n = (phase == PH_W'(PERIOD - 1)) ? '0 : phase + 1'b1;
                        k0_n    = ~k0;
                    end
                end
                S_DRAIN: begin
                    if (tmr == '0) begin
                        state_n = S_DONE;
                        finish  = 1'b1;
                    end else begin
                        tmr_n = tmr - 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Pattern is computed for the upcoming cycle so the registered o_tx lines up with k
    always_comb begin
        mode_sel = start_run ? i_mode  : mode_r;
        en_sel   = start_run ? i_ch_en : en_r;
        pat_bit  = mode_sel ? ~k0_n : ((phase_n < PH_W'(ON_CYC)) & ~phase_n[0]);
        tx_n     = INV_MASK;
        for (int i = 0; i < N_CH; i++) begin
            if ((state_n == S_RUN) && en_sel[i] && pat_bit)
                tx_n[i] = ~INV_MASK[i];
        end
    end

    assign o_busy = (state == S_RUN) || (state == S_DRAIN);
    assign o_done = (state == S_DONE);

    logic [N_CH-1:0]  rx_s1, rx_s2, rx_prv, rx_edge;
    logic [CNT_W-1:0] cnt [N_CH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_s1  <= INV_MASK;
            rx_s2  <= INV_MASK;
            rx_prv <= INV_MASK;
        end else begin
            rx_s1  <= i_rx;
            rx_s2  <= rx_s1;
            rx_prv <= rx_s2;
        end
    end

    assign rx_edge = (rx_s2 ^ INV_MASK) & ~(rx_prv ^ INV_MASK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else if (clr || start_run) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else if (o_busy) begin
            for (int i = 0; i < N_CH; i++) begin
                if (en_r[i] && rx_edge[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Lower bound clamps at zero so a small expected count never underflows
    logic [CNT_W:0]   exp_cnt, lo_bound;
    logic [CNT_W+1:0] hi_bound;
    logic [N_CH-1:0]  pass_vec;

    always_comb begin
        exp_cnt  = mode_r ? E_CONT : E_BURST;
        lo_bound = (exp_cnt > TOL_E) ? (exp_cnt - TOL_E) : '0;
        hi_bound = {1'b0, exp_cnt} + TOL_H;
        pass_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            pass_vec[i] = en_r[i] && ({1'b0, cnt[i]} >= lo_bound)
                                  && ({2'b00, cnt[i]} <= hi_bound);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result   <= '0;
            o_all_pass <= 1'b0;
        end else if (clr || start_run) begin
            o_result   <= '0;
            o_all_pass <= 1'b0;
        end else if (finish) begin
            o_result   <= pass_vec;
            o_all_pass <= (|en_r) && (pass_vec == en_r);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
        assign o_edge_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule

// File: tb/tb_ucie_clk_track_pattern_engine.sv
// Loopback bench for the clock/track pattern engine with edge masking/injection on lane 0.
module tb_ucie_clk_track_pattern_engine;

    localparam int         N_CH   = 3;
    localparam int         ITER   = 128;
    localparam int         ON     = 8;
    localparam int         OFF    = 8;
    localparam int         DRAIN  = 8;
    localparam int         TOL    = 4;
    localparam int         CNT_W  = 16;
    localparam logic [2:0] INV    = 3'b010;
    localparam int         L      = ITER * (ON + OFF);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  mode = 1'b0;
    logic                  clear = 1'b0;
    logic [N_CH-1:0]       ch_en = '0;
    logic [N_CH-1:0]       tx;
    logic [N_CH-1:0]       rx;
    logic                  busy, done, all_pass;
    logic [N_CH-1:0]       result;
    logic [N_CH*CNT_W-1:0] edge_cnt;

    int checks = 0;
    int errors = 0;

    ucie_clk_track_pattern_engine dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_mode     (mode),
        .i_clear    (clear),
        .i_ch_en    (ch_en),
        .o_tx       (tx),
        .i_rx       (rx),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result),
        .o_all_pass (all_pass),
        .o_edge_cnt (edge_cnt)
    );

    always #5 clk = ~clk;

    // Loopback channel: masks the first mask_left pulses on lane 0, injects
    // extra_left pulses into lane-0 idle gaps, and can hold lanes stuck at 0.
    int         mask_left = 0;
    int         extra_left = 0;
    int         zero_run = 0;
    logic       prev_tx0 = 1'b0;
    logic       masking = 1'b0;
    logic [2:0] stuck = '0;

    initial begin
        logic [2:0] r;
        rx = INV;
        forever begin
            @(negedge clk);
            r = tx;
            if (tx[0] && !prev_tx0 && mask_left > 0) begin
                masking = 1'b1;
                mask_left--;
            end
            if (!tx[0]) masking = 1'b0;
            if (masking) r[0] = 1'b0;
            zero_run = tx[0] ? 0 : zero_run + 1;
            if (busy && zero_run == 3 && extra_left > 0) begin
                r[0] = 1'b1;
                extra_left--;
            end
            prev_tx0 = tx[0];
            r = r & ~stuck;
            rx = r;
        end
    end

    function automatic logic [2:0] exp_tx(int j, logic m, logic [2:0] en);
        logic [2:0] inv = INV;
        logic [2:0] v;
        logic       act;
        for (int i = 0; i < N_CH; i++) begin
            act  = (j < L) && en[i] && ((j % 2) == 0) && (m || ((j % (ON + OFF)) < ON));
            v[i] = inv[i] ^ act;
        end
        return v;
    endfunction

    function automatic int exp_base(logic m);
        return m ? L / 2 : ITER * ON / 2;
    endfunction

    function automatic int model_cnt(int i, logic m, logic [2:0] en, int nm, int nx, logic [2:0] stk);
        int c;
        if (!en[i] || stk[i]) return 0;
        c = exp_base(m);
        if (i == 0) c = c - ((nm < c) ? nm : c) + nx;
        return c;
    endfunction

    function automatic int lane_cnt(int i);
        return int'(edge_cnt[i*CNT_W +: CNT_W]);
    endfunction

    // Drives one run; returns the negedge index (k) at which done was seen, -1 if never.
    task automatic do_run(input logic m, input logic [2:0] en, input int nm, input int nx,
                          input logic [2:0] stk, input int start_at, input int abort_at,
                          input int rst_at, output int done_at, output int tx_bad);
        int cyc;
        mode = m; ch_en = en; mask_left = nm; extra_left = nx; stuck = stk;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; tx_bad = 0; done_at = -1;
        while (cyc < 3000) begin
            if (done) begin
                done_at = cyc;
                break;
            end
            if (tx !== exp_tx(cyc, m, en)) tx_bad++;
            if (cyc == abort_at) begin
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                break;
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                break;
            end
            start = (cyc == start_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tx !== INV) begin errors++; $display("FAIL reset_tx got %b want %b", tx, INV); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 3'b000 || all_pass !== 1'b0) begin errors++; $display("FAIL reset_result got %b/%b want 000/0", result, all_pass); end
        checks++; if (edge_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", edge_cnt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst_loopback();
        int d, b;
        do_run(1'b0, 3'b111, 0, 0, 3'b000, -1, -1, -1, d, b);
        checks++; if (d !== L + DRAIN) begin errors++; $display("FAIL burst_done_latency got %0d want %0d", d, L + DRAIN); end
        checks++; if (b !== 0) begin errors++; $display("FAIL burst_tx_pattern got %0d bad cycles want 0", b); end
        for (int i = 0; i < N_CH; i++) begin
            checks++; if (lane_cnt(i) !== 512) begin errors++; $display("FAIL burst_cnt%0d got %0d want 512", i, lane_cnt(i)); end
        end
        checks++; if (result !== 3'b111 || all_pass !== 1'b1) begin errors++; $display("FAIL burst_result got %b/%b want 111/1", result, all_pass); end
    endtask

    task automatic test_continuous();
        int d, b;
        checks++; if (tx !== INV) begin errors++; $display("FAIL cont_tx_before got %b want %b", tx, INV); end
        do_run(1'b1, 3'b111, 0, 0, 3'b000, -1, -1, -1, d, b);
        checks++; if (d !== L + DRAIN) begin errors++; $display("FAIL cont_done_latency got %0d want %0d", d, L + DRAIN); end
        checks++; if (b !== 0) begin errors++; $display("FAIL cont_tx_pattern got %0d bad cycles want 0", b); end
        for (int i = 0; i < N_CH; i++) begin
            checks++; if (lane_cnt(i) !== 1024) begin errors++; $display("FAIL cont_cnt%0d got %0d want 1024", i, lane_cnt(i)); end
        end
        checks++; if (result !== 3'b111 || all_pass !== 1'b1) begin errors++; $display("FAIL cont_result got %b/%b want 111/1", result, all_pass); end
        checks++; if (tx !== INV) begin errors++; $display("FAIL cont_tx_after got %b want %b", tx, INV); end
    endtask

    task automatic test_stuck_lane();
        int d, b;
        do_run(1'b0, 3'b111, 0, 0, 3'b100, -1, -1, -1, d, b);
        checks++; if (lane_cnt(2) !== 0) begin errors++; $display("FAIL stuck_cnt2 got %0d want 0", lane_cnt(2)); end
        checks++; if (result !== 3'b011 || all_pass !== 1'b0) begin errors++; $display("FAIL stuck_result got %b/%b want 011/0", result, all_pass); end
    endtask

    task automatic test_tolerance();
        int d, b;
        int nm [3] = '{4, 5, 0};
        int nx [3] = '{0, 0, 4};
        int wc [3] = '{508, 507, 516};
        logic [2:0] wr [3] = '{3'b111, 3'b110, 3'b111};
        for (int t = 0; t < 3; t++) begin
            do_run(1'b0, 3'b111, nm[t], nx[t], 3'b000, -1, -1, -1, d, b);
            checks++; if (lane_cnt(0) !== wc[t]) begin errors++; $display("FAIL tol%0d_cnt0 got %0d want %0d", t, lane_cnt(0), wc[t]); end
            checks++; if (result !== wr[t]) begin errors++; $display("FAIL tol%0d_result got %b want %b", t, result, wr[t]); end
        end
    endtask

    task automatic test_clear_abort();
        int d, b;
        do_run(1'b0, 3'b111, 0, 0, 3'b000, -1, 1000, -1, d, b);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b done=%b want 0/0", busy, done); end
        checks++; if (edge_cnt !== '0) begin errors++; $display("FAIL abort_cnt got %h want 0", edge_cnt); end
        checks++; if (tx !== INV) begin errors++; $display("FAIL abort_tx got %b want %b", tx, INV); end
        checks++; if (result !== 3'b000) begin errors++; $display("FAIL abort_result got %b want 000", result); end
        do_run(1'b0, 3'b111, 0, 0, 3'b000, 500, -1, -1, d, b);
        checks++; if (d !== L + DRAIN) begin errors++; $display("FAIL restart_done_latency got %0d want %0d", d, L + DRAIN); end
        checks++; if (lane_cnt(1) !== 512 || result !== 3'b111) begin errors++; $display("FAIL restart_result got cnt1=%0d res=%b want 512/111", lane_cnt(1), result); end
    endtask

    task automatic test_reset_in_drain();
        int d, b;
        do_run(1'b0, 3'b111, 0, 0, 3'b000, -1, -1, L + 2, d, b);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_drain_state got busy=%b done=%b want 0/0", busy, done); end
        checks++; if (tx !== INV || edge_cnt !== '0) begin errors++; $display("FAIL rst_drain_out got tx=%b cnt=%h want %b/0", tx, edge_cnt, INV); end
        checks++; if (result !== 3'b000 || all_pass !== 1'b0) begin errors++; $display("FAIL rst_drain_result got %b/%b want 000/0", result, all_pass); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_lanes();
        int d, b;
        do_run(1'b0, 3'b000, 0, 0, 3'b000, -1, -1, -1, d, b);
        checks++; if (d !== L + DRAIN) begin errors++; $display("FAIL nolane_done got %0d want %0d", d, L + DRAIN); end
        checks++; if (result !== 3'b000 || all_pass !== 1'b0 || edge_cnt !== '0) begin errors++; $display("FAIL nolane_result got %b/%b cnt=%h want 000/0/0", result, all_pass, edge_cnt); end
    endtask

    task automatic test_random();
        int d, b, nm, nx, e, c;
        logic m;
        logic [2:0] en, stk, wr;
        logic wa;
        for (int r = 0; r < 4; r++) begin
            m   = 1'($urandom_range(0, 1));
            en  = 3'($urandom_range(0, 7));
            nm  = $urandom_range(0, 6);
            nx  = m ? 0 : $urandom_range(0, 4);
            stk = 3'(1 << $urandom_range(0, 2)) & 3'b110;
            do_run(m, en, nm, nx, stk, -1, -1, -1, d, b);
            e  = exp_base(m);
            wr = '0;
            for (int i = 0; i < N_CH; i++) begin
                c = model_cnt(i, m, en, nm, nx, stk);
                wr[i] = en[i] && (c >= e - TOL) && (c <= e + TOL);
                checks++; if (lane_cnt(i) !== c) begin errors++; $display("FAIL rand%0d_cnt%0d got %0d want %0d", r, i, lane_cnt(i), c); end
            end
            wa = (en != 3'b000) && (wr == en);
            checks++; if (result !== wr || all_pass !== wa) begin errors++; $display("FAIL rand%0d_result got %b/%b want %b/%b", r, result, all_pass, wr, wa); end
            checks++; if (b !== 0) begin errors++; $display("FAIL rand%0d_tx_pattern got %0d bad cycles want 0", r, b); end
        end
    endtask

    initial begin
        test_reset();
        test_burst_loopback();
        test_continuous();
        test_stuck_lane();
        test_tolerance();
        test_clear_abort();
        test_random();
        test_reset_in_drain();
        test_no_lanes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
